// File: rtl/stack_lifo.sv
// LIFO operand stack for the stack-based MIPS datapath: registered TOS, entry count,
// full/empty status and sticky overflow/underflow flags.
module stack_lifo #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  input  logic          push,
  input  logic          pop,
  output logic [N-1:0]  tos,
  output logic [AW:0]   sp,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW:0]   SpMax  = DEPTH[AW:0];
  localparam logic [AW:0]   SpOne  = 1;
  localparam logic [AW-1:0] IdxOne = 1;
  localparam logic [AW-1:0] IdxTwo = 2;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [N-1:0]  tos_q, tos_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          memWe;
  logic [AW-1:0] memWa;
  logic [N-1:0]  memRd;
  logic          isEmpty, isFull;

  assign isEmpty = (sp_q == '0);
  assign isFull  = (sp_q == SpMax);
  // Entry below the current top; only consumed when sp >= 2, so low-bit wrap is harmless.
  assign memRd   = mem_q[sp_q[AW-1:0] - IdxTwo];

  always_comb begin
    sp_d  = sp_q;
    tos_d = tos_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    memWe = 1'b0;
    memWa = sp_q[AW-1:0];
    unique case ({push, pop})
      2'b10: begin
        if (isFull) begin
          ovf_d = 1'b1;
        end else begin
          memWe = 1'b1;
          sp_d  = sp_q + SpOne;
          tos_d = din;
        end
      end
      2'b01: begin
        if (isEmpty) begin
          unf_d = 1'b1;
        end else if (sp_q == SpOne) begin
          sp_d  = '0;
          tos_d = '0;
        end else begin
          sp_d  = sp_q - SpOne;
          tos_d = memRd;
        end
      end
      2'b11: begin
        // Replace-top on a non-empty stack; an empty stack degrades to a plain push.
        memWe = 1'b1;
        tos_d = din;
        if (isEmpty) begin
          sp_d = SpOne;
        end else begin
          memWa = sp_q[AW-1:0] - IdxOne;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q  <= '0;
      tos_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      tos_q <= tos_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // The array is deliberately left uncleared by reset; sp and tos hide its contents.
  always_ff @(posedge clk) begin
    if (rst && memWe) begin
      mem_q[memWa] <= din;
    end
  end

  assign tos   = tos_q;
  assign sp    = sp_q;
  assign empty = isEmpty;
  assign full  = isFull;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_lifo.sv
// Directed testbench for stack_lifo; status is compared as {sp, tos, empty, full, ovf, unf}.
module tb_stack_lifo;
  localparam int N     = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop;
  logic [N-1:0]  din;
  logic [N-1:0]  tos;
  logic [AW:0]   sp;
  logic          empty, full, ovf, unf;
  logic [15:0]   obs, exp;
  int            checks = 0;
  int            errors = 0;

  stack_lifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop),
    .tos(tos), .sp(sp), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  assign obs = {sp, tos, empty, full, ovf, unf};

  // Inputs change 1 ns after the rising edge, and outputs are sampled there as well.
  task automatic cycle(input logic p, input logic q, input logic [N-1:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
  endtask

  task automatic fill_silent();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i * 17));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 8'hFF);
      exp = {4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_hold %0d: got %h expected %h", i, obs, exp); end
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'hA5);
      exp = {4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_idle %0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_fill_drain();
    logic [N-1:0] d;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      d = 8'(i * 17);
      cycle(1'b1, 1'b0, d);
      exp = {i[3:0], d, 1'b0, (i == 8), 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fill %0d: got %h expected %h", i, obs, exp); end
    end
    cycle(1'b0, 1'b0, 8'h00);
    exp = {4'd8, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL full_idle: got %h expected %h", obs, exp); end
    for (int i = 7; i >= 0; i--) begin
      d = 8'(i * 17);
      cycle(1'b0, 1'b1, 8'h00);
      exp = {i[3:0], d, (i == 0), 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL drain %0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_silent();
    cycle(1'b1, 1'b0, 8'h99);
    exp = {4'd8, 8'h88, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ovf_push: got %h expected %h", obs, exp); end
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd7, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ovf_pop: got %h expected %h", obs, exp); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL unf_pop: got %h expected %h", obs, exp); end
    cycle(1'b1, 1'b0, 8'h5A);
    exp = {4'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL unf_push: got %h expected %h", obs, exp); end
  endtask

  task automatic test_push_pop();
    do_reset();
    cycle(1'b1, 1'b0, 8'h01);
    cycle(1'b1, 1'b0, 8'h02);
    exp = {4'd2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pp_setup: got %h expected %h", obs, exp); end
    cycle(1'b1, 1'b1, 8'hC3);
    exp = {4'd2, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pp_replace: got %h expected %h", obs, exp); end
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pp_pop: got %h expected %h", obs, exp); end
    cycle(1'b1, 1'b0, 8'hEE);
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pp_below: got %h expected %h", obs, exp); end
    do_reset();
    cycle(1'b1, 1'b1, 8'h3C);
    exp = {4'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL pp_empty: got %h expected %h", obs, exp); end
  endtask

  task automatic test_full_replace();
    do_reset();
    fill_silent();
    cycle(1'b1, 1'b1, 8'hD7);
    exp = {4'd8, 8'hD7, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL full_replace: got %h expected %h", obs, exp); end
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd7, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL full_replace_pop: got %h expected %h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_silent();
    cycle(1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd5, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_setup: got %h expected %h", obs, exp); end
    rst = 1'b0;
    cycle(1'b1, 1'b0, 8'hAA);
    rst = 1'b1;
    exp = {4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_reset: got %h expected %h", obs, exp); end
    cycle(1'b0, 1'b1, 8'h00);
    exp = {4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_pop: got %h expected %h", obs, exp); end
  endtask

  initial begin
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_full_replace();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_lifo.md
Name: stack_lifo

Overview:
- Hardware LIFO stack for the multi-cycle stack-based MIPS datapath.
- Read-side counterpart to the datapath's load/store registers: it takes operands pushed by the datapath and returns them in reverse order.
- Provides a registered top-of-stack (TOS) output, stack pointer, full/empty status and sticky overflow/underflow error flags for the controller.

Parameters:
N, 8, data word width in bits
DEPTH, 8, number of stack entries
AW, 3, pointer index width; must satisfy 2**AW == DEPTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
din  input  N  data word to push
push  input  1  push request, sampled on rising edge
pop  input  1  pop request, sampled on rising edge
tos  output  N  registered current top-of-stack value; 0 when empty
sp  output  AW+1  entry count, range 0..DEPTH
empty  output  1  high when sp == 0
full  output  1  high when sp == DEPTH
ovf  output  1  sticky overflow error flag
unf  output  1  sticky underflow error flag

Behaviour:
Reset:
- rst == 0 at a rising edge: sp=0, tos=0, ovf=0, unf=0. Hence empty=1, full=0.
- Storage array is not cleared; its contents are don't-care after reset.
- Reset has priority over push/pop in the same cycle.

Status outputs:
- empty and full are decoded combinationally from the sp register only. No combinational path from push/pop/din to any output.

Operation table (evaluated at a rising edge with rst==1):
- idle (push=0, pop=0): no state change.
- push only, not full: mem[sp] <= din; sp <= sp+1; tos <= din.
- push only, full: no change to mem/sp/tos; ovf <= 1.
- pop only, sp >= 2: sp <= sp-1; tos <= mem[sp-2].
- pop only, sp == 1: sp <= 0; tos <= 0.
- pop only, empty: no change to mem/sp/tos; unf <= 1.
- push and pop, not empty (including full): replace top. mem[sp-1] <= din; tos <= din; sp unchanged; no error flag.
- push and pop, empty: treated as push only. mem[0] <= din; sp <= 1; tos <= din; no unf.

Timing and flags:
- Latency: all outputs reflect an operation in the cycle after the sampling edge. tos is never stale relative to sp.
- ovf and unf, once set, stay high until reset. Both may be high simultaneously.
- An error-flagged operation leaves all other state unchanged; the stack stays fully usable afterwards.

Arithmetic:
- sp arithmetic is unsigned AW+1 bits.
- Index mem with the low AW bits. Indices used are always in range 0..DEPTH-1 by construction.
- No wrap-around: sp never exceeds DEPTH and never goes below 0.

Implementation:
- Single-port write, asynchronous-read register array.
- The tos register is updated from the write data or the array read at sp-2, as listed above.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, then rst=1 with push=pop=0 -> sp=0, tos=0, empty=1, full=0, ovf=0, unf=0 throughout.
2. Fill and drain: push 0x11,0x22,...,0x88 on consecutive cycles -> sp counts 1..8, tos tracks each value, full=1 at sp=8. Then 8 pops -> tos 0x77,0x66,...,0x11, then 0; empty=1; no error flags.
3. Overflow: at full, push 0x99 -> sp stays 8, tos stays 0x88, ovf=1. Then pop -> tos=0x77; ovf remains 1.
4. Underflow: from reset, pop -> unf=1, sp=0, tos=0. Then push 0x5A -> sp=1, tos=0x5A; unf still 1.
5. Simultaneous push+pop: with stack holding 0x01,0x02 (sp=2), push+pop with din=0xC3 -> sp=2, tos=0xC3. Then pop -> tos=0x01. Separately, on an empty stack, push+pop with din=0x3C -> sp=1, tos=0x3C, unf=0.
6. Reset mid-operation: with sp=5 and ovf=1, assert rst=0 in the same cycle as push=1 -> next cycle sp=0, tos=0, ovf=0. Then a single pop -> unf=1, proving the stale array contents are not exposed.
